// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (IF) and load/store (D).
// Optional `define ARB_PERF_CNT_EN adds the perf_if_stall counter output.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       perf_if_stall
`endif
);

    // state   | meaning
    // IDLE    | free; may issue a request this cycle
    // WAIT_IF | fetch read outstanding, counting down to data return
    // WAIT_D  | load read outstanding, counting down to data return

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TC = SW'(STARVE_MAX);
    localparam logic [3:0]    LAT       = 4'(MEM_LAT);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT=%0d outside supported range 1..15", MEM_LAT);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_t;

    state_t         state;
    logic [3:0]     wait_cnt;
    logic [SW-1:0]  starve_cnt;
    logic           idle;
    logic           d_win;
    logic           if_win;
    logic           last;

    // Outputs are forced quiet while Reset is held so nothing issues during reset.
    always_comb begin
        idle      = (state == IDLE) && !Reset;
        d_win     = idle && d_req && !(if_req && (starve_cnt == STARVE_TC));
        if_win    = idle && if_req && !d_win;
        last      = (wait_cnt == 4'd1) && !Reset;

        if_gnt    = if_win;
        d_gnt     = d_win;
        mem_en    = if_win || d_win;
        mem_we    = d_win && d_we;
        mem_addr  = d_win ? d_addr : (if_win ? if_addr : '0);
        mem_wdata = d_win ? d_wdata : '0;

        if_rvalid = (state == WAIT_IF) && last;
        d_rvalid  = (state == WAIT_D) && last;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;

        stall_if  = if_req && !if_gnt && !Reset;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_win && !d_we) begin
                        state    <= WAIT_D;
                        wait_cnt <= LAT;
                    end else if (if_win) begin
                        state    <= WAIT_IF;
                        wait_cnt <= LAT;
                    end
                end
                WAIT_IF, WAIT_D: begin
                    if (wait_cnt == 4'd1) begin
                        state    <= IDLE;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 4'd0;
                end
            endcase

            // Counts D wins only while fetch is actually waiting.
            if (!if_req || if_win)
                starve_cnt <= '0;
            else if (d_win && (starve_cnt != STARVE_TC))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            perf_if_stall <= 16'd0;
        else if (stall_if && (perf_if_stall != 16'hFFFF))
            perf_if_stall <= perf_if_stall + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=1 main instance, MEM_LAT=3 reset instance).
module tb_mem_port_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;

    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_if;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, stall_if3;
    logic [15:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
    logic [15:0] mem_rdata3 = 16'hDEAD;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_if_stall, perf_if_stall3;
`endif

    int checks = 0;
    int errors = 0;

    // Memory model: 256 words, preset to addr ^ 16'hA5A5, one cycle read latency.
    logic [15:0] mem [0:255];
    logic [7:0]  rd_addr;
    logic        mem_init;

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
            rd_addr <= 8'd0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        rd_addr <= mem_addr[7:0];
        end
    end
    assign mem_rdata = mem[rd_addr];

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_stall(perf_if_stall)
`endif
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .Clock(Clock), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .stall_if(stall_if3)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_stall(perf_if_stall3)
`endif
    );

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic quiet_inputs();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        if_req = 1'b1; d_req = 1'b1; if_addr = 16'h0003; d_addr = 16'h0004;
        @(negedge Clock);
        checks++;
        if ({if_gnt, d_gnt, mem_en, stall_if, if_rvalid, d_rvalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {if_gnt, d_gnt, mem_en, stall_if, if_rvalid, d_rvalid});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        next_cycle();
        quiet_inputs();
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if ({mem_en, stall_if, if_rvalid, d_rvalid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0000", {mem_en, stall_if, if_rvalid, d_rvalid});
        end
    endtask

    task automatic test_if_read();
        next_cycle();
        if_req = 1'b1; if_addr = 16'h000A;
        @(negedge Clock);
        checks++;
        if ({if_gnt, d_gnt, mem_en, mem_we, stall_if} !== 5'b10100 || mem_addr !== 16'h000A) begin
            errors++;
            $display("FAIL if_issue: got gnt/dg/en/we/st=%b addr=%h expected 10100 000a",
                     {if_gnt, d_gnt, mem_en, mem_we, stall_if}, mem_addr);
        end
        next_cycle();
        if_addr = 16'h000B;
        @(negedge Clock);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'hA5AF) begin
            errors++;
            $display("FAIL if_return: got rvalid=%b rdata=%h expected 1 a5af", if_rvalid, if_rdata);
        end
        checks++;
        if ({if_gnt, mem_en, stall_if} !== 3'b001) begin
            errors++;
            $display("FAIL if_wait_stall: got gnt/en/stall=%b expected 001", {if_gnt, mem_en, stall_if});
        end
        next_cycle();
        @(negedge Clock);
        checks++;
        if (if_gnt !== 1'b1 || mem_addr !== 16'h000B || if_rvalid !== 1'b0 || if_rdata !== 16'h0) begin
            errors++;
            $display("FAIL if_idle_t2: got gnt=%b addr=%h rvalid=%b rdata=%h expected 1 000b 0 0000",
                     if_gnt, mem_addr, if_rvalid, if_rdata);
        end
        next_cycle();
        if_req = 1'b0;
        @(negedge Clock);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'hA5AE) begin
            errors++;
            $display("FAIL if_return2: got rvalid=%b rdata=%h expected 1 a5ae", if_rvalid, if_rdata);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        bit exp_if, exp_d, exp_irv, exp_drv;
        int k;
        next_cycle();
        for (int c = 0; c < 20; c++) begin
            if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
            if_addr = 16'h0030; d_addr = 16'h0020; d_wdata = 16'h5555;
            k = c / 2;
            exp_if  = (c % 2 == 0) && (k % 5 == 4);
            exp_d   = (c % 2 == 0) && !exp_if;
            exp_irv = (c % 2 == 1) && (k % 5 == 4);
            exp_drv = (c % 2 == 1) && !exp_irv;
            @(negedge Clock);
            checks++;
            if ({if_gnt, d_gnt, stall_if, if_rvalid, d_rvalid} !== {exp_if, exp_d, !exp_if, exp_irv, exp_drv}) begin
                errors++;
                $display("FAIL starve_c%0d: got ig/dg/st/irv/drv=%b expected %b", c,
                         {if_gnt, d_gnt, stall_if, if_rvalid, d_rvalid}, {exp_if, exp_d, !exp_if, exp_irv, exp_drv});
            end
            if (exp_if) begin
                checks++;
                if (mem_we !== 1'b0 || mem_wdata !== 16'h0 || mem_addr !== 16'h0030) begin
                    errors++;
                    $display("FAIL starve_if_fields_c%0d: got we=%b wdata=%h addr=%h expected 0 0000 0030",
                             c, mem_we, mem_wdata, mem_addr);
                end
            end
            if (exp_drv) begin
                checks++;
                if (d_rdata !== 16'hA585 || if_rdata !== 16'h0) begin
                    errors++;
                    $display("FAIL starve_drdata_c%0d: got d=%h if=%h expected a585 0000", c, d_rdata, if_rdata);
                end
            end
            if (exp_irv) begin
                checks++;
                if (if_rdata !== 16'hA595 || d_rdata !== 16'h0) begin
                    errors++;
                    $display("FAIL starve_ifrdata_c%0d: got if=%h d=%h expected a595 0000", c, if_rdata, d_rdata);
                end
            end
            next_cycle();
        end
        quiet_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234;
        @(negedge Clock);
        checks++;
        if ({d_gnt, mem_en, mem_we, d_rvalid} !== 4'b1110 || mem_addr !== 16'h0010 || mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL store0: got dg/en/we/rv=%b addr=%h wdata=%h expected 1110 0010 1234",
                     {d_gnt, mem_en, mem_we, d_rvalid}, mem_addr, mem_wdata);
        end
        next_cycle();
        d_addr = 16'h0011; d_wdata = 16'hBEEF;
        @(negedge Clock);
        checks++;
        if ({d_gnt, mem_en, mem_we, d_rvalid} !== 4'b1110 || mem_addr !== 16'h0011 || mem_wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL store1: got dg/en/we/rv=%b addr=%h wdata=%h expected 1110 0011 beef",
                     {d_gnt, mem_en, mem_we, d_rvalid}, mem_addr, mem_wdata);
        end
        next_cycle();
        quiet_inputs();
        @(negedge Clock);
        checks++;
        if ({mem_en, d_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL store_after: got en/rv=%b expected 00", {mem_en, d_rvalid});
        end
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        @(negedge Clock);
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL load_back_issue: got gnt=%b we=%b expected 1 0", d_gnt, mem_we);
        end
        next_cycle();
        d_req = 1'b0; if_req = 1'b1; if_addr = 16'h0011;
        @(negedge Clock);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 16'h1234 || if_gnt !== 1'b0 || stall_if !== 1'b1) begin
            errors++;
            $display("FAIL load_back_data: got rv=%b rdata=%h ig=%b st=%b expected 1 1234 0 1",
                     d_rvalid, d_rdata, if_gnt, stall_if);
        end
        next_cycle();
        next_cycle();
        if_req = 1'b0;
        @(negedge Clock);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL fetch_back_data: got rv=%b rdata=%h expected 1 beef", if_rvalid, if_rdata);
        end
        next_cycle();
    endtask

    task automatic test_withdraw();
        if_req = 1'b1; if_addr = 16'h0040;
        @(negedge Clock);
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL withdraw_if_gnt: got %b expected 1", if_gnt);
        end
        next_cycle();
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
        @(negedge Clock);
        checks++;
        if (d_gnt !== 1'b0 || mem_en !== 1'b0 || if_rvalid !== 1'b1 || if_rdata !== 16'hA5E5) begin
            errors++;
            $display("FAIL withdraw_wait: got dg=%b en=%b irv=%b ird=%h expected 0 0 1 a5e5",
                     d_gnt, mem_en, if_rvalid, if_rdata);
        end
        next_cycle();
        d_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clock);
            checks++;
            if ({mem_en, d_gnt, d_rvalid} !== 3'b000) begin
                errors++;
                $display("FAIL withdraw_none_c%0d: got en/dg/drv=%b expected 000", c, {mem_en, d_gnt, d_rvalid});
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_access();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060;
        @(negedge Clock);
        checks++;
        if (d_gnt3 !== 1'b1 || mem_en3 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_issue: got gnt=%b en=%b expected 1 1", d_gnt3, mem_en3);
        end
        next_cycle();
        d_req = 1'b0; Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if ({if_gnt3, d_gnt3, mem_en3, mem_we3, stall_if3, if_rvalid3, d_rvalid3} !== 7'b0 ||
            {mem_addr3, mem_wdata3, if_rdata3, d_rdata3} !== 64'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got ctrl=%b data=%h expected 0 0",
                     {if_gnt3, d_gnt3, mem_en3, mem_we3, stall_if3, if_rvalid3, d_rvalid3},
                     {mem_addr3, mem_wdata3, if_rdata3, d_rdata3});
        end
        next_cycle();
        Reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            checks++;
            if (d_rvalid3 !== 1'b0 || d_rdata3 !== 16'h0) begin
                errors++;
                $display("FAIL midrst_no_rvalid_c%0d: got rv=%b rdata=%h expected 0 0000", c, d_rvalid3, d_rdata3);
            end
            next_cycle();
        end
        d_req = 1'b1; d_addr = 16'h0061;
        @(negedge Clock);
        checks++;
        if (d_gnt3 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle_after: got gnt=%b expected 1", d_gnt3);
        end
        next_cycle();
        quiet_inputs();
        for (int c = 0; c < 4; c++) next_cycle();
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf_cnt();
        Reset = 1'b1;
        next_cycle();
        Reset = 1'b0;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020; if_addr = 16'h0030;
        for (int c = 0; c < 7; c++) next_cycle();
        quiet_inputs();
        @(negedge Clock);
        checks++;
        if (perf_if_stall !== 16'd7) begin
            errors++;
            $display("FAIL perf_count: got %0d expected 7", perf_if_stall);
        end
        next_cycle();
        next_cycle();
        @(negedge Clock);
        checks++;
        if (perf_if_stall !== 16'd7) begin
            errors++;
            $display("FAIL perf_hold: got %0d expected 7", perf_if_stall);
        end
    endtask
`endif

    initial begin
        quiet_inputs();
        Reset = 1'b1;
        mem_init = 1'b1;
        next_cycle();
        next_cycle();
        mem_init = 1'b0;
        test_reset();
        test_if_read();
        test_starvation();
        test_back_to_back();
        test_withdraw();
        test_reset_mid_access();
`ifdef ARB_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
